// File: rtl/uart_mem_loader_pkg.sv
// Shared types and default sizing for the UART memory loader.
package uart_mem_loader_pkg;

    localparam int unsigned DEF_WORD_SIZE  = 24;
    localparam int unsigned DEF_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_SEND,
        DUMP_BUSY,
        DUMP_FIN
    } state_e;

endpackage

// File: rtl/uart_mem_loader_addr_counter.sv
// Sequential word counter: clear, increment and terminal-count flag.
// One extra bit so a full 2**ADDR_WIDTH run terminates without wrapping.
module mem_addr_counter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign addr = count_q[ADDR_WIDTH-1:0];
    assign last = (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_mem_loader.sv
// Sequential memory loader (UART RX -> RAM) and dumper (RAM -> UART TX).
// Optional running checksum enabled by defining UART_MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_load,
    input  logic                  start_dump,
    input  logic [WORD_SIZE-1:0]  dataToMem,
    input  logic                  new_rx_data_indicate,
    input  logic                  txReady,
    output logic [WORD_SIZE-1:0]  dataFromMem,
    output logic                  txStart,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [WORD_SIZE-1:0]  mem_wr_data,
    input  logic [WORD_SIZE-1:0]  mem_rd_data,
    output logic                  busy,
    output logic                  load_done,
    output logic                  dump_done,
    output logic [WORD_SIZE-1:0]  checksum
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                state_q;
    logic [WORD_SIZE-1:0]  data_from_mem_q;
    logic                  tx_start_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_wr_en_q;
    logic [WORD_SIZE-1:0]  mem_wr_data_q;
    logic                  busy_q;
    logic                  load_done_q;
    logic                  dump_done_q;

    logic                  start_accept;
    logic                  rx_write;
    logic                  cnt_inc;
    logic [ADDR_WIDTH-1:0] cnt_addr;
    logic                  cnt_last;

    assign start_accept = (state_q == IDLE) && (start_load || start_dump);
    assign rx_write     = (state_q == LOAD) && new_rx_data_indicate;
    assign cnt_inc      = rx_write ||
                          ((state_q == DUMP_BUSY) && !txReady && !cnt_last);

    mem_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_accept),
        .inc  (cnt_inc),
        .addr (cnt_addr),
        .last (cnt_last)
    );

    // mem_addr is loaded on entry to DUMP_RD so it is already valid throughout
    // DUMP_RD; the RAM's one-cycle read then lands in time for DUMP_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            data_from_mem_q <= '0;
            tx_start_q      <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_en_q     <= 1'b0;
            mem_wr_data_q   <= '0;
            busy_q          <= 1'b0;
            load_done_q     <= 1'b0;
            dump_done_q     <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            mem_wr_en_q <= 1'b0;
            load_done_q <= 1'b0;
            dump_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_load) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else if (start_dump) begin
                        state_q    <= DUMP_RD;
                        busy_q     <= 1'b1;
                        mem_addr_q <= '0;
                    end
                end
                LOAD: begin
                    if (new_rx_data_indicate) begin
                        mem_wr_en_q   <= 1'b1;
                        mem_addr_q    <= cnt_addr;
                        mem_wr_data_q <= dataToMem;
                        if (cnt_last) begin
                            load_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                DUMP_RD: begin
                    mem_addr_q <= cnt_addr;
                    state_q    <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    data_from_mem_q <= mem_rd_data;
                    state_q         <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (txReady) begin
                        tx_start_q <= 1'b1;
                        state_q    <= DUMP_BUSY;
                    end
                end
                DUMP_BUSY: begin
                    if (!txReady) begin
                        if (cnt_last) begin
                            state_q <= DUMP_FIN;
                        end else begin
                            mem_addr_q <= cnt_addr + ADDR_ONE;
                            state_q    <= DUMP_RD;
                        end
                    end
                end
                DUMP_FIN: begin
                    if (txReady) begin
                        dump_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (rx_write) begin
            checksum_q <= checksum_q + dataToMem;
        end else if (state_q == DUMP_WAIT) begin
            checksum_q <= checksum_q + mem_rd_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign dataFromMem = data_from_mem_q;
    assign txStart     = tx_start_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign dump_done   = dump_done_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed self-checking bench for uart_mem_loader (MEM_DEPTH=4, ADDR_WIDTH=2).
module tb_uart_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load;
    logic        start_dump;
    logic [23:0] dataToMem;
    logic        new_rx_data_indicate;
    logic        txReady;
    logic [23:0] dataFromMem;
    logic        txStart;
    logic [1:0]  mem_addr;
    logic        mem_wr_en;
    logic [23:0] mem_wr_data;
    logic [23:0] mem_rd_data;
    logic        busy;
    logic        load_done;
    logic        dump_done;
    logic [23:0] checksum;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .WORD_SIZE  (24),
        .ADDR_WIDTH (2),
        .MEM_DEPTH  (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_load           (start_load),
        .start_dump           (start_dump),
        .dataToMem            (dataToMem),
        .new_rx_data_indicate (new_rx_data_indicate),
        .txReady              (txReady),
        .dataFromMem          (dataFromMem),
        .txStart              (txStart),
        .mem_addr             (mem_addr),
        .mem_wr_en            (mem_wr_en),
        .mem_wr_data          (mem_wr_data),
        .mem_rd_data          (mem_rd_data),
        .busy                 (busy),
        .load_done            (load_done),
        .dump_done            (dump_done),
        .checksum             (checksum)
    );

    // RAM model with synchronous read and a bench-side preload port
    logic [23:0] ram [4];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_addr = '0;
    logic [23:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
    end

    // encoder model: txReady drops 3 cycles after txStart, recovers after 5 more
    int tx_cnt = 0;
    always @(posedge clk) begin
        if (rst) tx_cnt <= 0;
        else if (txStart) tx_cnt <= 1;
        else if (tx_cnt != 0) tx_cnt <= (tx_cnt == 8) ? 0 : tx_cnt + 1;
    end
    assign txReady = !(tx_cnt >= 3 && tx_cnt <= 7);

    logic [1:0]  wr_addr_q[$];
    logic [23:0] wr_data_q[$];
    logic [23:0] tx_q[$];
    int cyc = 0, ld_cnt = 0, ld_with_wr = 0, ld_idx = 0;
    int tx_bad = 0, tx_t = 0, dd_cnt = 0, dd_t = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
        end
        if (load_done) begin
            ld_cnt++;
            ld_with_wr = int'(mem_wr_en);
            ld_idx = wr_addr_q.size();
        end
        if (txStart) begin
            tx_q.push_back(dataFromMem);
            tx_t = cyc;
            if (!txReady) tx_bad++;
        end
        if (dump_done) begin
            dd_cnt++;
            dd_t = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic l, input logic d);
        start_load = l;
        start_dump = d;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
    endtask

    task automatic rx_word(input logic [23:0] d);
        new_rx_data_indicate = 1'b1;
        dataToMem = d;
        @(negedge clk);
        new_rx_data_indicate = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [23:0] load_words [4] = '{24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF};
    logic [23:0] dump_words [4] = '{24'h000011, 24'h000022, 24'h000033, 24'h000044};

    initial begin
        int wr_base, ld_base, tx_base, dd_base, cycles;
        rst = 1'b1;
        start_load = 1'b0;
        start_dump = 1'b0;
        dataToMem = '0;
        new_rx_data_indicate = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_wr_en", 32'(mem_wr_en), 0);
        check_eq("rst_txstart", 32'(txStart), 0);
        check_eq("rst_addr", 32'(mem_addr), 0);
        check_eq("rst_data_from_mem", 32'(dataFromMem), 0);
        check_eq("rst_checksum", 32'(checksum), 0);
        rst = 1'b0;
        @(negedge clk);

        // load, with both starts together and a stray start_dump mid-load
        wr_base = wr_addr_q.size();
        ld_base = ld_cnt;
        tx_base = tx_q.size();
        pulse_start(1'b1, 1'b1);
        check_eq("load_busy", 32'(busy), 1);
        for (int unsigned i = 0; i < 4; i++) begin
            if (i == 2) pulse_start(1'b0, 1'b1);
            rx_word(load_words[i]);
        end
        repeat (3) @(negedge clk);
        check_eq("load_wr_count", 32'(wr_addr_q.size() - wr_base), 4);
        for (int i = 0; i < 4; i++) begin
            if (wr_addr_q.size() > wr_base + i) begin
                check_eq($sformatf("load_addr%0d", i), 32'(wr_addr_q[wr_base + i]), 32'(i));
                check_eq($sformatf("load_data%0d", i), 32'(wr_data_q[wr_base + i]), 32'(load_words[i]));
                check_eq($sformatf("load_ram%0d", i), 32'(ram[i]), 32'(load_words[i]));
            end
        end
        check_eq("load_done_count", 32'(ld_cnt - ld_base), 1);
        check_eq("load_done_with_wr", 32'(ld_with_wr), 1);
        check_eq("load_done_at_4th", 32'(ld_idx - wr_base), 4);
        check_eq("load_idle_busy", 32'(busy), 0);
        check_eq("load_no_tx", 32'(tx_q.size() - tx_base), 0);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        check_eq("load_checksum", 32'(checksum), 32'h00BE0245);
`else
        check_eq("load_checksum", 32'(checksum), 0);
`endif

        // rx pulse while idle
        rx_word(24'h555555);
        check_eq("idle_rx_no_wr", 32'(wr_addr_q.size() - wr_base), 4);
        check_eq("idle_rx_addr", 32'(mem_addr), 3);

        // dump
        for (int i = 0; i < 4; i++) begin
            pre_en = 1'b1;
            pre_addr = 2'(i);
            pre_data = dump_words[i];
            @(negedge clk);
        end
        pre_en = 1'b0;
        wr_base = wr_addr_q.size();
        tx_base = tx_q.size();
        dd_base = dd_cnt;
        pulse_start(1'b0, 1'b1);
        cycles = 0;
        while (dd_cnt == dd_base && cycles < 500) begin
            new_rx_data_indicate = (cycles == 10);
            dataToMem = 24'h666666;
            @(negedge clk);
            cycles++;
        end
        new_rx_data_indicate = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("dump_done_count", 32'(dd_cnt - dd_base), 1);
        check_eq("dump_tx_count", 32'(tx_q.size() - tx_base), 4);
        for (int i = 0; i < 4; i++) begin
            if (tx_q.size() > tx_base + i)
                check_eq($sformatf("dump_tx%0d", i), 32'(tx_q[tx_base + i]), 32'(dump_words[i]));
        end
        check_eq("dump_tx_while_busy", 32'(tx_bad), 0);
        check_eq("dump_done_after_tx", 32'(dd_t > tx_t), 1);
        check_eq("dump_rx_no_wr", 32'(wr_addr_q.size() - wr_base), 0);
        check_eq("dump_idle_busy", 32'(busy), 0);
        check_eq("dump_data_held", 32'(dataFromMem), 32'h44);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        check_eq("dump_checksum", 32'(checksum), 32'hAA);
`else
        check_eq("dump_checksum", 32'(checksum), 0);
`endif

        // abort a load after two writes, then restart
        wr_base = wr_addr_q.size();
        ld_base = ld_cnt;
        pulse_start(1'b1, 1'b0);
        rx_word(24'h0000A1);
        rx_word(24'h0000A2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_wr_en", 32'(mem_wr_en), 0);
        check_eq("abort_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check_eq("abort_no_done", 32'(ld_cnt - ld_base), 0);
        pulse_start(1'b1, 1'b0);
        for (int unsigned i = 0; i < 4; i++) rx_word(24'h0000B0 + 24'(i));
        repeat (2) @(negedge clk);
        check_eq("restart_wr_count", 32'(wr_addr_q.size() - wr_base), 6);
        if (wr_addr_q.size() >= wr_base + 6) begin
            check_eq("restart_first_addr", 32'(wr_addr_q[wr_base + 2]), 0);
            check_eq("restart_first_data", 32'(wr_data_q[wr_base + 2]), 32'hB0);
            check_eq("restart_last_addr", 32'(wr_addr_q[wr_base + 5]), 3);
        end
        check_eq("restart_done_count", 32'(ld_cnt - ld_base), 1);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        check_eq("restart_checksum", 32'(checksum), 32'h2C6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
